cp0_exception_ctrl: RTL and testbench

Sequences the CP0 register file when the pipeline takes an exception or interrupt, or executes ERET. Sits at the MEM/WB boundary. It does four things:
- prioritises pending exception sources and synchronised interrupts;
- drives the CP0 per-register write-enable vector and write data over a fixed multi-cycle sequence;
- then issues a pipeline flush plus a PC redirect to the exception vector, or to EPC for ERET;
- stalls the front end while the sequence runs.

---
 rtl/cp0_pkg.sv | 27 ++
 rtl/cp0_exception_ctrl_if.sv | 47 ++++
 rtl/exc_priority_enc.sv | 44 ++++
 rtl/cp0_exception_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for CP0 exception sequencing: ExcCodes, CP0 register
// indices, the general exception vector and the sequencer state type.
package cp0_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned CP0_BADVADDR = 8;
    localparam int unsigned CP0_STATUS   = 12;
    localparam int unsigned CP0_CAUSE    = 13;
    localparam int unsigned CP0_EPC      = 14;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXC_WR,
        ST_ERET_WR,
        ST_REDIR
    } state_e;

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// Pipeline/CP0 side signals of the exception controller; the controller
// connects through the slave modport, the pipeline/CP0 side through master.
interface cp0_exception_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_valid;
    logic [WIDTH-1:0] mem_pc;
    logic             mem_bd;
    logic [6:0]       mem_exc;
    logic [WIDTH-1:0] mem_badvaddr;
    logic             mem_eret;
    logic [5:0]       hw_int;
    logic [1:0]       sw_int;
    logic [7:0]       status_im;
    logic             status_ie;
    logic             status_exl;
    logic [WIDTH-1:0] epc_in;

    logic [WIDTH-1:0] cp0_we;
    logic [WIDTH-1:0] cp0_epc;
    logic [WIDTH-1:0] cp0_badvaddr;
    logic [4:0]       cp0_exccode;
    logic             cp0_bd;
    logic             cp0_exl;
    logic             cp0_ie;
    logic [7:0]       cp0_im;
    logic             stall_req;
    logic             flush;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             busy;

    modport master (
        output mem_valid, mem_pc, mem_bd, mem_exc, mem_badvaddr, mem_eret,
               hw_int, sw_int, status_im, status_ie, status_exl, epc_in,
        input  cp0_we, cp0_epc, cp0_badvaddr, cp0_exccode, cp0_bd, cp0_exl,
               cp0_ie, cp0_im, stall_req, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  mem_valid, mem_pc, mem_bd, mem_exc, mem_badvaddr, mem_eret,
               hw_int, sw_int, status_im, status_ie, status_exl, epc_in,
        output cp0_we, cp0_epc, cp0_badvaddr, cp0_exccode, cp0_bd, cp0_exl,
               cp0_ie, cp0_im, stall_req, flush, redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/exc_priority_enc.sv
// Picks the highest-priority pending cause and its ExcCode, and reports
// whether that cause loads BadVAddr (and whether from the PC).
module exc_priority_enc
    import cp0_pkg::*;
(
    input  logic       int_pend,
    input  logic [6:0] mem_exc,
    output logic       take,
    output logic [4:0] exccode,
    output logic       badv_wr,
    output logic       badv_pc
);

    always_comb begin
        take    = 1'b1;
        exccode = EXC_INT;
        badv_wr = 1'b0;
        badv_pc = 1'b0;
        if (int_pend) begin
            exccode = EXC_INT;
        end else if (mem_exc[0]) begin
            exccode = EXC_ADEL;
            badv_wr = 1'b1;
            badv_pc = 1'b1;
        end else if (mem_exc[1]) begin
            exccode = EXC_RI;
        end else if (mem_exc[2]) begin
            exccode = EXC_OV;
        end else if (mem_exc[3]) begin
            exccode = EXC_SYS;
        end else if (mem_exc[4]) begin
            exccode = EXC_BP;
        end else if (mem_exc[5]) begin
            exccode = EXC_ADEL;
            badv_wr = 1'b1;
        end else if (mem_exc[6]) begin
            exccode = EXC_ADES;
            badv_wr = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Exception/ERET sequencer at MEM/WB: takes a cause in IDLE, writes CP0 for
// one cycle, then flushes and redirects the PC for one cycle.
module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(EXC_VECTOR_DEFAULT),
    parameter int unsigned      SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    cp0_exception_ctrl_if.slave bus
);

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [5:0] hw_sync;
    logic       int_pend;
    logic       exc_any, enc_badv_wr, enc_badv_pc;
    logic [4:0] enc_code;
    logic       take_exc, take_eret;

    state_e           state_q, state_d;
    logic [4:0]       code_q, code_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] badv_q, badv_d;
    logic [WIDTH-1:0] rpc_q, rpc_d;
    logic             bd_q, bd_d;
    logic             old_exl_q, old_exl_d;
    logic             badv_wr_q, badv_wr_d;
    logic             is_eret_q, is_eret_d;
    logic             exl_q, exl_d;
    logic             ie_q, ie_d;

    logic [WIDTH-1:0] we;
    logic [WIDTH-1:0] rpc_o;
    logic             exl_o, ie_o, flush_o;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.hw_int};
    assign hw_sync  = sync_q[SYNC_STAGES-1];
    assign int_pend = bus.status_ie & ~bus.status_exl
                    & (|(bus.status_im & {hw_sync, bus.sw_int}));

    exc_priority_enc u_prio (
        .int_pend (int_pend),
        .mem_exc  (bus.mem_exc),
        .take     (exc_any),
        .exccode  (enc_code),
        .badv_wr  (enc_badv_wr),
        .badv_pc  (enc_badv_pc)
    );

    assign take_exc  = bus.mem_valid & exc_any;
    assign take_eret = bus.mem_valid & bus.mem_eret & ~exc_any;

    // Write-data fields are captured only when the matching enable will fire,
    // so every CP0 write-data output holds steady while its enable is low.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        epc_d     = epc_q;
        badv_d    = badv_q;
        rpc_d     = rpc_q;
        bd_d      = bd_q;
        old_exl_d = old_exl_q;
        badv_wr_d = badv_wr_q;
        is_eret_d = is_eret_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        we        = '0;
        exl_o     = exl_q;
        ie_o      = ie_q;
        rpc_o     = rpc_q;
        flush_o   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (take_exc) begin
                    state_d   = ST_EXC_WR;
                    is_eret_d = 1'b0;
                    code_d    = enc_code;
                    bd_d      = bus.mem_bd;
                    old_exl_d = bus.status_exl;
                    badv_wr_d = enc_badv_wr;
                    if (!bus.status_exl) epc_d = bus.mem_pc;
                    if (enc_badv_wr) badv_d = enc_badv_pc ? bus.mem_pc : bus.mem_badvaddr;
                end else if (take_eret) begin
                    state_d   = ST_ERET_WR;
                    is_eret_d = 1'b1;
                end
            end
            ST_EXC_WR: begin
                we[CP0_CAUSE]    = 1'b1;
                we[CP0_STATUS]   = 1'b1;
                we[CP0_EPC]      = ~old_exl_q;
                we[CP0_BADVADDR] = badv_wr_q;
                exl_o   = 1'b1;
                ie_o    = bus.status_ie;
                exl_d   = exl_o;
                ie_d    = ie_o;
                state_d = ST_REDIR;
            end
            ST_ERET_WR: begin
                we[CP0_STATUS] = 1'b1;
                exl_o   = 1'b0;
                ie_o    = bus.status_ie;
                exl_d   = exl_o;
                ie_d    = ie_o;
                state_d = ST_REDIR;
            end
            ST_REDIR: begin
                flush_o = 1'b1;
                rpc_o   = is_eret_q ? bus.epc_in : EXC_VECTOR;
                rpc_d   = rpc_o;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            code_q    <= '0;
            epc_q     <= '0;
            badv_q    <= '0;
            rpc_q     <= '0;
            bd_q      <= 1'b0;
            old_exl_q <= 1'b0;
            badv_wr_q <= 1'b0;
            is_eret_q <= 1'b0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            badv_q    <= badv_d;
            rpc_q     <= rpc_d;
            bd_q      <= bd_d;
            old_exl_q <= old_exl_d;
            badv_wr_q <= badv_wr_d;
            is_eret_q <= is_eret_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
        end
    end

    assign bus.cp0_we         = we;
    assign bus.cp0_epc        = epc_q;
    assign bus.cp0_badvaddr   = badv_q;
    assign bus.cp0_exccode    = code_q;
    assign bus.cp0_bd         = bd_q;
    assign bus.cp0_exl        = exl_o;
    assign bus.cp0_ie         = ie_o;
    assign bus.cp0_im         = bus.status_im;
    assign bus.stall_req      = (state_q != ST_IDLE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.flush          = flush_o;
    assign bus.redirect_valid = flush_o;
    assign bus.redirect_pc    = rpc_o;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: a cycle-age event model checked every cycle,
// plus directed vectors with literal expectations.
module tb_cp0_exception_ctrl;

    localparam int          SYNC = 2;
    localparam logic [31:0] VEC  = 32'hBFC00380;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    cp0_exception_ctrl_if #(.WIDTH(32)) bus ();

    cp0_exception_ctrl #(
        .WIDTH       (32),
        .EXC_VECTOR  (32'hBFC00380),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age counts cycles since a take (0 = idle), kind says
    // whether the sequence is an exception or an ERET.
    int          age;
    logic        kind_exc;
    logic        m_old_exl, m_badv_wr, m_bd, m_exl, m_ie;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_rpc;
    logic [5:0]  hist [SYNC];
    int          code_tbl [7] = '{4, 10, 12, 8, 9, 4, 5};

    initial begin : model
        logic [31:0] e_we, e_rpc;
        logic        e_exl, e_ie, e_flush, pend, take_exc;
        int          first;
        forever begin
            @(negedge clk);
            if (rst) begin
                age = 0; kind_exc = 0; m_old_exl = 0; m_badv_wr = 0; m_bd = 0;
                m_exl = 0; m_ie = 0; m_code = 0; m_epc = 0; m_badv = 0; m_rpc = 0;
                for (int i = 0; i < SYNC; i++) hist[i] = '0;
            end
            e_we = '0; e_flush = 0; e_exl = m_exl; e_ie = m_ie; e_rpc = m_rpc;
            if (age == 1) begin
                if (kind_exc) begin
                    e_we  = 32'h0000_3000 | (m_old_exl ? 32'h0 : 32'h0000_4000)
                          | (m_badv_wr ? 32'h0000_0100 : 32'h0);
                    e_exl = 1'b1;
                end else begin
                    e_we  = 32'h0000_1000;
                    e_exl = 1'b0;
                end
                e_ie = bus.status_ie;
            end else if (age == 2) begin
                e_flush = 1'b1;
                e_rpc   = kind_exc ? VEC : bus.epc_in;
            end
            check("m_we",    bus.cp0_we,         e_we);
            check("m_epc",   bus.cp0_epc,        m_epc);
            check("m_badv",  bus.cp0_badvaddr,   m_badv);
            check("m_code",  32'(bus.cp0_exccode), 32'(m_code));
            check("m_bd",    32'(bus.cp0_bd),    32'(m_bd));
            check("m_exl",   32'(bus.cp0_exl),   32'(e_exl));
            check("m_ie",    32'(bus.cp0_ie),    32'(e_ie));
            check("m_im",    32'(bus.cp0_im),    32'(bus.status_im));
            check("m_stall", 32'(bus.stall_req), 32'(age != 0));
            check("m_busy",  32'(bus.busy),      32'(age != 0));
            check("m_flush", 32'(bus.flush),     32'(e_flush));
            check("m_rv",    32'(bus.redirect_valid), 32'(e_flush));
            check("m_rpc",   bus.redirect_pc,    e_rpc);
            m_exl = e_exl; m_ie = e_ie; m_rpc = e_rpc;
            if (!rst) begin
                if (age == 0) begin
                    pend = bus.status_ie && !bus.status_exl
                        && ((bus.status_im & {hist[SYNC-1], bus.sw_int}) != 8'h0);
                    take_exc = bus.mem_valid && (pend || bus.mem_exc != 7'h0);
                    if (take_exc) begin
                        age = 1; kind_exc = 1;
                        m_bd = bus.mem_bd; m_old_exl = bus.status_exl; m_badv_wr = 0;
                        if (!bus.status_exl) m_epc = bus.mem_pc;
                        if (pend) begin
                            m_code = 5'd0;
                        end else begin
                            first = -1;
                            for (int i = 0; i < 7; i++)
                                if (first < 0 && bus.mem_exc[i]) first = i;
                            m_code = 5'(code_tbl[first]);
                            if (first == 0 || first == 5 || first == 6) begin
                                m_badv_wr = 1;
                                m_badv = (first == 0) ? bus.mem_pc : bus.mem_badvaddr;
                            end
                        end
                    end else if (bus.mem_valid && bus.mem_eret) begin
                        age = 1; kind_exc = 0;
                    end
                end else begin
                    age = (age == 1) ? 2 : 0;
                end
                for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = bus.hw_int;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                       input logic [31:0] badv, input logic eret);
        bus.mem_valid = 1'b1; bus.mem_pc = pc; bus.mem_bd = bd;
        bus.mem_exc = exc; bus.mem_badvaddr = badv; bus.mem_eret = eret;
    endtask

    task automatic bubble();
        bus.mem_valid = 1'b0; bus.mem_exc = '0; bus.mem_eret = 1'b0; bus.mem_bd = 1'b0;
    endtask

    initial begin : stim
        bus.mem_valid = 0; bus.mem_pc = '0; bus.mem_bd = 0; bus.mem_exc = '0;
        bus.mem_badvaddr = '0; bus.mem_eret = 0; bus.hw_int = '0; bus.sw_int = '0;
        bus.status_im = '0; bus.status_ie = 0; bus.status_exl = 0; bus.epc_in = '0;

        cyc(); cyc();
        @(negedge clk);
        check("rst_we", bus.cp0_we, 32'h0);
        check("rst_rpc", bus.redirect_pc, 32'h0);
        rst = 1'b0;
        cyc();

        // Ov only
        put(32'h8000_0010, 0, 7'b0000100, 32'h0, 0);
        cyc(); bubble();
        @(negedge clk);
        check("ov_we", bus.cp0_we, 32'h0000_7000);
        check("ov_code", 32'(bus.cp0_exccode), 32'd12);
        check("ov_epc", bus.cp0_epc, 32'h8000_0010);
        cyc();
        @(negedge clk);
        check("ov_flush", 32'(bus.flush), 32'd1);
        check("ov_rpc", bus.redirect_pc, 32'hBFC0_0380);
        cyc();

        // RI + AdEL-load + Sys
        put(32'h8000_0014, 0, 7'b0101010, 32'h1234_5678, 0);
        cyc(); bubble();
        @(negedge clk);
        check("ri_code", 32'(bus.cp0_exccode), 32'd10);
        check("ri_we8", 32'(bus.cp0_we[8]), 32'd0);
        cyc(); cyc();

        // AdES in a delay slot
        put(32'h8000_0020, 1, 7'b1000000, 32'h8000_1003, 0);
        cyc(); bubble();
        @(negedge clk);
        check("ades_we", bus.cp0_we, 32'h0000_7100);
        check("ades_badv", bus.cp0_badvaddr, 32'h8000_1003);
        check("ades_code", 32'(bus.cp0_exccode), 32'd5);
        check("ades_bd", 32'(bus.cp0_bd), 32'd1);
        cyc(); cyc();

        // AdEL-fetch uses mem_pc as BadVAddr
        put(32'h8000_0040, 0, 7'b0000001, 32'h1234_5678, 0);
        cyc(); bubble();
        @(negedge clk);
        check("adelf_badv", bus.cp0_badvaddr, 32'h8000_0040);
        check("adelf_code", 32'(bus.cp0_exccode), 32'd4);
        cyc(); cyc();

        // Exception with EXL already set: EPC not written
        bus.status_exl = 1'b1;
        put(32'h8000_0050, 0, 7'b0010000, 32'h0, 0);
        cyc(); bubble();
        @(negedge clk);
        check("exl_we", bus.cp0_we, 32'h0000_3000);
        check("exl_epc_hold", bus.cp0_epc, 32'h8000_0040);
        cyc(); cyc();
        bus.status_exl = 1'b0;

        // ERET
        bus.epc_in = 32'h8000_0100;
        put(32'h8000_0060, 0, 7'b0, 32'h0, 1);
        cyc(); bubble();
        @(negedge clk);
        check("eret_we", bus.cp0_we, 32'h0000_1000);
        check("eret_exl", 32'(bus.cp0_exl), 32'd0);
        cyc();
        @(negedge clk);
        check("eret_rv", 32'(bus.redirect_valid), 32'd1);
        check("eret_rpc", bus.redirect_pc, 32'h8000_0100);
        cyc();

        // ERET + Sys: exception wins
        put(32'h8000_0070, 0, 7'b0001000, 32'h0, 1);
        cyc(); bubble();
        @(negedge clk);
        check("erets_code", 32'(bus.cp0_exccode), 32'd8);
        check("erets_we", bus.cp0_we, 32'h0000_7000);
        cyc(); cyc();

        // Interrupt pulse on hw_int[2], taken SYNC cycles after assertion
        bus.status_ie = 1'b1; bus.status_im = 8'h10;
        put(32'h8000_0200, 0, 7'b0, 32'h0, 0);
        cyc();
        bus.hw_int = 6'b000100;
        @(negedge clk); check("int_c0_busy", 32'(bus.busy), 32'd0);
        cyc(); bus.hw_int = '0;
        @(negedge clk); check("int_c1_busy", 32'(bus.busy), 32'd0);
        cyc();
        @(negedge clk); check("int_c2_busy", 32'(bus.busy), 32'd0);
        cyc();
        @(negedge clk);
        check("int_c3_busy", 32'(bus.busy), 32'd1);
        check("int_code", 32'(bus.cp0_exccode), 32'd0);
        check("int_epc", bus.cp0_epc, 32'h8000_0200);
        cyc(); cyc(); cyc();

        // Same pulse with EXL set: never taken
        bus.status_exl = 1'b1;
        bus.hw_int = 6'b000100;
        cyc(); bus.hw_int = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); check("intexl_busy", 32'(bus.busy), 32'd0);
            cyc();
        end
        bus.status_exl = 1'b0;

        // Pending interrupt during a bubble waits for a valid instruction
        bubble();
        bus.hw_int = 6'b000100;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk); check("intbub_busy", 32'(bus.busy), 32'd0);
        end
        cyc();
        put(32'h8000_0300, 0, 7'b0, 32'h0, 0);
        cyc(); bubble(); bus.hw_int = '0;
        @(negedge clk);
        check("intbub_take", 32'(bus.busy), 32'd1);
        check("intbub_epc", bus.cp0_epc, 32'h8000_0300);
        cyc(); cyc(); cyc();
        bus.status_ie = 1'b0; bus.status_im = 8'h00;

        // Reset during EXC_WR aborts the sequence
        put(32'h8000_0400, 0, 7'b0001000, 32'h0, 0);
        cyc(); bubble();
        rst = 1'b1;
        @(negedge clk);
        check("rstm_we", bus.cp0_we, 32'h0);
        check("rstm_epc", bus.cp0_epc, 32'h0);
        check("rstm_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            check("rstm_rv", 32'(bus.redirect_valid), 32'd0);
            check("rstm_rpc", bus.redirect_pc, 32'h0);
        end
        cyc(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("post_rst_rv", 32'(bus.redirect_valid), 32'd0);
        end

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
